mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised modulo-N up/down counter. It is the successor to the 8-bit count-enable/carry-in/sync-clear counter IP.
- It adds the following over that counter:
  - configurable width and modulus
  - direction control
  - synchronous parallel load
  - asynchronous active-low reset
  - terminal-count and carry-out outputs for cascading (e.g. BCD digit chains)
  - a registered wrap pulse
- It serves as a general timebase/event counter inside larger designs.

Parameters:
- WIDTH, 8: counter register width in bits.
- MODULUS, 256: count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration must fail outside this range.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  count enable. Gates counting only.
- cin  in  1  carry-in. Counting occurs only when cnt_en and cin are both 1.
- updown  in  1  direction: 1 = up, 0 = down.
- sclr  in  1  synchronous clear.
- sload  in  1  synchronous parallel load.
- data  in  WIDTH  load value.
- q  out  WIDTH  registered count.
- tc  out  1  terminal count, combinational from q and updown.
- cout  out  1  carry-out = tc & cnt_en & cin, combinational, for cascading into the next stage's cin.
- wrap  out  1  registered one-cycle pulse, high in the cycle after q wrapped.

Behaviour:
- Reset:
  - rst_n=0 forces q=0 and wrap=0 immediately, with no clock edge required. This applies mid-count as well.
  - While reset is asserted: tc = (updown ? 0==MODULUS-1 : 1), so in down mode tc=1 and in up mode tc=0. cout follows the tc formula.
  - On release, counting resumes at the first rising edge where rst_n=1.
- Priority at each rising edge, highest first:
  - sclr=1: q<=0. This is independent of cnt_en, cin and sload.
  - sload=1: q<=data if data<=MODULUS-1, else q<=MODULUS-1 (saturate). Independent of cnt_en and cin.
  - cnt_en=1 & cin=1 & updown=1: q<=(q==MODULUS-1) ? 0 : q+1.
  - cnt_en=1 & cin=1 & updown=0: q<=(q==0) ? MODULUS-1 : q-1.
  - Otherwise q holds.
- Latency: q changes exactly one edge after the qualifying inputs are sampled. Inputs are sampled only at rising edges; cin toggling between edges has no effect.
- tc: up mode, tc=1 when q==MODULUS-1; down mode, tc=1 when q==0. It updates combinationally on a direction change.
- cout is high in the same cycle as the count that will wrap. A cascaded upper stage therefore increments on the same edge the lower stage wraps.
- wrap:
  - wrap<=1 for one cycle when a counting step (not sclr, not sload) takes q from MODULUS-1 to 0 (up) or from 0 to MODULUS-1 (down).
  - Otherwise wrap<=0.
  - sclr or sload in the same cycle as a terminal count suppresses wrap.
- Arithmetic is unsigned, modulo MODULUS. q must never hold a value >= MODULUS.
- MODULUS=2**WIDTH reduces to natural binary roll-over.
- A direction change takes effect at the next edge with no dead cycle.
- Asynchronous reset asserted in the same cycle as sclr/sload/count: reset wins. No partial update.

Test Plan:
- Reset mid-count:
  - Stimulus: WIDTH=8, MODULUS=10, count up to q=5; drop rst_n 3 ns after an edge.
  - Response: q=0 and wrap=0 before the next edge. After release, q reaches 1 at the first edge with cnt_en=cin=1.
- Up wrap:
  - Stimulus: MODULUS=10, cnt_en=cin=updown=1 for 12 edges from 0.
  - Response: q = 1..9,0,1,2. tc=cout=1 only while q=9. wrap=1 only in the cycle after q became 0.
- Carry-in gating:
  - Stimulus: cin toggled every clock period (sampled 1,0,1,0…) with cnt_en=1.
  - Response: q increments on every other edge. With cnt_en=0 and cin=1, q holds and cout=0 at q=9.
- Clear/load priority:
  - Stimulus: at q=2 assert sclr and sload (data=7) together with cin=1 for one edge.
  - Response: q=0, not 3 or 7. Then sload with data=7 gives q=7. Then data=200 gives q=9 with no wrap pulse.
- Down count:
  - Stimulus: updown=0 from q=1, 3 counting edges.
  - Response: q = 0, 9, 8. tc=1 while q=0. wrap=1 in the cycle after q=9.
  - Stimulus: switch updown=1 at q=8.
  - Response: next edge gives q=9 and tc=1.
- Cascade:
  - Stimulus: two MODULUS=10 instances, low stage cout driving high stage cin, shared cnt_en=1, low stage cin=1, 100 edges.
  - Response: {high,low} steps 00..99 then 00. Both couts are high at 99.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, saturating load, carry cascade and wrap pulse.
// tc/cout are combinational so a cascaded stage advances on the same edge this one wraps.
module mod_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             cin,
    input  logic             updown,
    input  logic             sclr,
    input  logic             sload,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             cout,
    output logic             wrap
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic step;
    logic [WIDTH-1:0] load_val;

    assign step     = cnt_en & cin;
    assign tc       = updown ? (q == MAX) : (q == '0);
    assign cout     = tc & step;
    // Out-of-range load values saturate so q never leaves 0..MODULUS-1.
    assign load_val = (data > MAX) ? MAX : data;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= ~sclr & ~sload & step & tc;
            if (sclr) begin
                q <= '0;
            end else if (sload) begin
                q <= load_val;
            end else if (step) begin
                if (updown) begin
                    q <= (q == MAX) ? '0 : q + WIDTH'(1);
                end else begin
                    q <= (q == '0) ? MAX : q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: a MODULUS=10 single stage plus a two-digit cascade.
module tb_mod_updown_counter;

    localparam int M = 10;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       cnt_en = 1'b0, cin = 1'b0, updown = 1'b1, sclr = 1'b0, sload = 1'b0;
    logic [7:0] data = '0;
    logic [7:0] q;
    logic       tc, cout, wrap;

    logic       casc_en = 1'b0;
    logic [7:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_cout, hi_cout, lo_wrap, hi_wrap;

    typedef struct {
        int q;
        bit wrap;
    } exp_t;

    exp_t exp_fifo[$];
    int   casc_fifo[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_q = 0;
    bit   m_wrap = 1'b0;

    always #5 clock = ~clock;

    mod_updown_counter #(.WIDTH(8), .MODULUS(M)) u_dut (
        .clock(clock), .rst_n(rst_n), .cnt_en(cnt_en), .cin(cin), .updown(updown),
        .sclr(sclr), .sload(sload), .data(data), .q(q), .tc(tc), .cout(cout), .wrap(wrap)
    );

    mod_updown_counter #(.WIDTH(8), .MODULUS(M)) u_lo (
        .clock(clock), .rst_n(rst_n), .cnt_en(casc_en), .cin(1'b1), .updown(1'b1),
        .sclr(1'b0), .sload(1'b0), .data(8'd0), .q(lo_q), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap)
    );

    mod_updown_counter #(.WIDTH(8), .MODULUS(M)) u_hi (
        .clock(clock), .rst_n(rst_n), .cnt_en(casc_en), .cin(lo_cout), .updown(1'b1),
        .sclr(1'b0), .sload(1'b0), .data(8'd0), .q(hi_q), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, predict and compare the edge result.
    task automatic step(input bit en, input bit ci, input bit ud, input bit sc, input bit sl,
                        input int d, input string tag);
        bit   exp_tc, exp_cout;
        exp_t e, got;
        @(negedge clock);
        cnt_en = en; cin = ci; updown = ud; sclr = sc; sload = sl; data = 8'(d);
        #1;
        exp_tc   = ud ? (m_q == M - 1) : (m_q == 0);
        exp_cout = exp_tc & en & ci;
        check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
        check({tag, ".cout"}, 32'(cout), 32'(exp_cout));
        m_wrap = !sc && !sl && en && ci && exp_tc;
        if (sc)           m_q = 0;
        else if (sl)      m_q = (d > M - 1) ? M - 1 : d;
        else if (en & ci) m_q = ud ? ((m_q == M - 1) ? 0 : m_q + 1) : ((m_q == 0) ? M - 1 : m_q - 1);
        e.q = m_q;
        e.wrap = m_wrap;
        exp_fifo.push_back(e);
        @(posedge clock);
        #1;
        got = exp_fifo.pop_front();
        check({tag, ".q"}, 32'(q), 32'(got.q));
        check({tag, ".wrap"}, 32'(wrap), 32'(got.wrap));
    endtask

    initial begin
        int val;

        // Reset state, tc follows direction while held in reset
        #12;
        updown = 1'b0;
        #1 check("rst.tc_down", 32'(tc), 32'd1);
        updown = 1'b1;
        #1 check("rst.tc_up", 32'(tc), 32'd0);
        check("rst.q", 32'(q), 32'd0);
        check("rst.wrap", 32'(wrap), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        // Reset mid-count
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, "pre_rst");
        check("pre_rst.q5", 32'(q), 32'd5);
        #2 rst_n = 1'b0;
        #1 check("async_rst.q", 32'(q), 32'd0);
        check("async_rst.wrap", 32'(wrap), 32'd0);
        m_q = 0;
        m_wrap = 1'b0;
        @(posedge clock);
        #1 check("held_rst.q", 32'(q), 32'd0);
        rst_n = 1'b1;
        step(1, 1, 1, 0, 0, 0, "post_rst");
        check("post_rst.q1", 32'(q), 32'd1);

        // Up wrap from 0
        step(0, 0, 1, 1, 0, 0, "clr");
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0, 0, $sformatf("up%0d", i));

        // Carry-in gating: cin sampled 1,0,1,0...
        for (int i = 0; i < 8; i++) step(1, (i % 2) == 0, 1, 0, 0, 0, $sformatf("cin%0d", i));
        check("cin.q6", 32'(q), 32'd6);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, "to9");
        step(0, 1, 1, 0, 0, 0, "en_off_at9");

        // Clear/load priority and saturation
        step(0, 0, 1, 1, 0, 0, "clr2");
        step(1, 1, 1, 0, 0, 0, "c1");
        step(1, 1, 1, 0, 0, 0, "c2");
        step(1, 1, 1, 1, 1, 7, "clr_ld");
        check("clr_ld.q0", 32'(q), 32'd0);
        step(0, 0, 1, 0, 1, 7, "ld7");
        step(0, 0, 1, 0, 1, 200, "ld_sat");
        check("ld_sat.q9", 32'(q), 32'd9);
        step(1, 1, 1, 0, 1, 3, "ld_at_tc");

        // Down count through zero, then direction change
        step(0, 0, 1, 1, 0, 0, "clr3");
        step(1, 1, 1, 0, 0, 0, "to1");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, $sformatf("dn%0d", i));
        check("dn.q8", 32'(q), 32'd8);
        step(1, 1, 1, 0, 0, 0, "dir_up");
        step(0, 0, 1, 0, 0, 0, "hold9");

        // Two-digit cascade, 100 edges
        val = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            casc_en = 1'b1;
            #1;
            check($sformatf("casc%0d.lo_cout", i), 32'(lo_cout), 32'((val % 10) == 9));
            check($sformatf("casc%0d.hi_cout", i), 32'(hi_cout), 32'(val == 99));
            val = (val + 1) % 100;
            casc_fifo.push_back(val);
            @(posedge clock);
            #1;
            check($sformatf("casc%0d.val", i), 32'(hi_q) * 10 + 32'(lo_q), 32'(casc_fifo.pop_front()));
        end
        @(negedge clock);
        casc_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
